// File: rtl/cnt_seq_ctrl.sv
// Sequencing controller for an external cascaded 4-bit counter chain.
// Produces a programmable-period one-shot/periodic timer with irq and saturating event count.
module cnt_seq_ctrl #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned EVT_W  = 8,
    localparam int unsigned W     = 4 * STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             tick,
    input  logic             mode,
    input  logic [W-1:0]     period,
    input  logic [W-1:0]     cnt_q,
    output logic             cnt_ce,
    output logic             cnt_r,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic [EVT_W-1:0] evt_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     period_l_q, period_l_d;
    logic             mode_l_q, mode_l_d;
    logic             irq_q, irq_d;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;

    logic run;
    logic en;
    logic match;

    always_comb begin
        run   = (state_q == StRun);
        en    = run & tick & ~hold;
        match = en & (cnt_q == period_l_q);
    end

    // The chain gives clear priority over enable, so cnt_r alone restarts an interval.
    assign cnt_ce  = en;
    assign cnt_r   = ~run | match | (run & stop);
    assign busy    = run;
    assign done    = (state_q == StDone);
    assign irq     = irq_q;
    assign evt_cnt = evt_cnt_q;

    always_comb begin
        state_d    = state_q;
        period_l_d = period_l_q;
        mode_l_d   = mode_l_q;
        irq_d      = 1'b0;
        evt_cnt_d  = evt_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    period_l_d = period;
                    mode_l_d   = mode;
                    evt_cnt_d  = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                // stop beats a coincident match: no irq, no count
                if (stop) begin
                    state_d = StIdle;
                end else if (match) begin
                    irq_d = 1'b1;
                    if (evt_cnt_q != {EVT_W{1'b1}}) begin
                        evt_cnt_d = evt_cnt_q + EVT_W'(1);
                    end
                    if (!mode_l_q) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (start) begin
                    period_l_d = period;
                    mode_l_d   = mode;
                    evt_cnt_d  = '0;
                    state_d    = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            period_l_q <= '0;
            mode_l_q   <= 1'b0;
            irq_q      <= 1'b0;
            evt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            period_l_q <= period_l_d;
            mode_l_q   <= mode_l_d;
            irq_q      <= irq_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Randomized + directed bench for cnt_seq_ctrl with a tick-counting reference model
// and an irq scoreboard; the counter chain is modelled here as plain W-bit arithmetic.
module tb_cnt_seq_ctrl;

    localparam int STAGES = 2;
    localparam int W      = 4 * STAGES;
    localparam int EVT_W  = 8;
    localparam int EVT_MAX = (1 << EVT_W) - 1;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, hold, tick, mode;
    logic [W-1:0]     period;
    logic [W-1:0]     cnt_q;
    logic             cnt_ce, cnt_r, busy, done, irq;
    logic [EVT_W-1:0] evt_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [EVT_W-1:0] evt;
        logic             done;
    } exp_t;
    exp_t sb_q[$];

    // reference model: state, latched config, events, enabled ticks in current interval
    int m_state  = M_IDLE;
    int m_period = 0;
    bit m_mode   = 1'b0;
    int m_evt    = 0;
    int m_ticks  = 0;

    cnt_seq_ctrl #(.STAGES(STAGES), .EVT_W(EVT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .hold   (hold),
        .tick   (tick),
        .mode   (mode),
        .period (period),
        .cnt_q  (cnt_q),
        .cnt_ce (cnt_ce),
        .cnt_r  (cnt_r),
        .busy   (busy),
        .done   (done),
        .irq    (irq),
        .evt_cnt(evt_cnt)
    );

    always #5 clk = ~clk;

    // counter chain: clear has priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_q <= '0;
        else if (cnt_r)  cnt_q <= '0;
        else if (cnt_ce) cnt_q <= cnt_q + 1'b1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        bit   en, match;
        exp_t e;
        #2;
        en    = (m_state == M_RUN) && tick && !hold;
        match = en && (m_ticks == m_period);
        check("cnt_ce", cnt_ce, en);
        check("cnt_r", cnt_r, (m_state != M_RUN) || match || (m_state == M_RUN && stop));
        case (m_state)
            M_RUN: begin
                if (stop) begin
                    m_state = M_IDLE;
                end else if (match) begin
                    m_evt   = (m_evt < EVT_MAX) ? m_evt + 1 : EVT_MAX;
                    m_ticks = 0;
                    if (!m_mode) m_state = M_DONE;
                    e.evt  = m_evt[EVT_W-1:0];
                    e.done = !m_mode;
                    sb_q.push_back(e);
                end else if (en) begin
                    m_ticks++;
                end
            end
            default: begin
                if (m_state == M_DONE && stop) begin
                    m_state = M_IDLE;
                end else if (start) begin
                    m_period = int'(period);
                    m_mode   = mode;
                    m_evt    = 0;
                    m_ticks  = 0;
                    m_state  = M_RUN;
                end
            end
        endcase
        @(posedge clk);
        #1;
        check("busy", busy, m_state == M_RUN);
        check("done", done, m_state == M_DONE);
        check("evt_cnt", evt_cnt, m_evt);
    endtask

    // irq monitor: every pulse must match the head of the scoreboard and vice versa
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (irq || sb_q.size() > 0) begin
                if (sb_q.size() == 0) begin
                    check("irq_unexpected", irq, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("irq_pulse", irq, 1);
                    check("irq_evt", evt_cnt, e.evt);
                    check("irq_done", done, e.done);
                end
            end
        end
    end

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; hold = 1'b0;
    endtask

    task automatic go(input int p, input bit md);
        period = W'(p); mode = md; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int cap, output int n);
        n = 0;
        while (m_state != M_DONE && n < cap) begin
            step();
            n++;
        end
        if (m_state != M_DONE) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n;
        int saved;
        rst_n = 1'b0; tick = 1'b0; mode = 1'b0; period = '0;
        idle_inputs();
        #1;
        check("rst_cnt_r", cnt_r, 1);
        check("rst_cnt_ce", cnt_ce, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_irq", irq, 0);
        check("rst_evt", evt_cnt, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // one-shot, period 5
        tick = 1'b1;
        go(5, 1'b0);
        run_until_done("oneshot", 20, n);
        check("oneshot_len", n, 6);
        check("oneshot_cnt_q", cnt_q, 0);
        check("oneshot_evt", evt_cnt, 1);

        // periodic with tick every 2nd clock, into saturation
        stop = 1'b1; step(); stop = 1'b0;
        tick = 1'b0;
        go(3, 1'b1);
        for (int i = 0; i < 2420; i++) begin
            tick = i[0];
            step();
        end
        check("sat_evt", evt_cnt, EVT_MAX);

        // hold at cnt_q==4
        stop = 1'b1; step(); stop = 1'b0;
        tick = 1'b1;
        go(9, 1'b0);
        n = 0;
        while (m_ticks != 4 && n < 20) begin step(); n++; end
        hold = 1'b1;
        repeat (10) step();
        check("hold_cnt_q", cnt_q, 4);
        hold = 1'b0;
        run_until_done("hold", 20, n);
        check("hold_release_len", n, 6);

        // stop colliding with a match
        go(2, 1'b1);
        n = 0;
        while (!(m_ticks == 2 && m_evt >= 1) && n < 30) begin step(); n++; end
        saved = m_evt;
        stop = 1'b1; step(); stop = 1'b0;
        check("collide_busy", busy, 0);
        check("collide_evt", evt_cnt, saved);

        // start during RUN is ignored
        go(4, 1'b1);
        repeat (3) step();
        period = 8'd2; start = 1'b1; step(); start = 1'b0;
        repeat (20) step();
        check("restart_ignored_evt", evt_cnt, 4);

        // period 0: match on every enabled tick
        stop = 1'b1; step(); stop = 1'b0;
        go(0, 1'b1);
        repeat (10) step();
        check("p0_evt", evt_cnt, 10);

        // period 255: 256-tick interval
        stop = 1'b1; step(); stop = 1'b0;
        go(255, 1'b0);
        run_until_done("p255", 300, n);
        check("p255_len", n, 256);

        // restart from DONE with period 1
        go(1, 1'b0);
        check("redo_evt_clear", evt_cnt, 0);
        check("redo_busy", busy, 1);
        run_until_done("redo", 10, n);
        check("redo_len", n, 2);
        check("redo_evt", evt_cnt, 1);

        // async reset mid-RUN
        go(2, 1'b1);
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt_r", cnt_r, 1);
        check("mid_rst_cnt_ce", cnt_ce, 0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_evt", evt_cnt, 0);
        m_state = M_IDLE; m_period = 0; m_mode = 1'b0; m_evt = 0; m_ticks = 0;
        @(posedge clk); #1;
        check("mid_rst_irq_after", irq, 0);
        rst_n = 1'b1;

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            start  = ($urandom_range(0, 19) == 0);
            stop   = ($urandom_range(0, 39) == 0);
            hold   = ($urandom_range(0, 7) == 0);
            tick   = $urandom_range(0, 1) == 1;
            mode   = $urandom_range(0, 1) == 1;
            period = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                 : W'($urandom_range(0, 5));
            step();
        end

        idle_inputs();
        tick = 1'b0;
        step(); step();
        check("sb_drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
